// File: rtl/pwm_gate_deadtime.sv
// Gate-drive output stage for the LLC half-bridge: synchronises the DSP PWM commands,
// inserts a minimum dead time between legs and blocks both gates on trip, disable or overlap.
module pwm_gate_deadtime #(
  parameter int unsigned DEADTIME_CNT = 25
) (
  input  logic CLK_50M,
  input  logic Rst_n,
  input  logic PWMEN,
  input  logic ProTect,
  input  logic ResetD,
  input  logic PWM_A_IN,
  input  logic PWM_B_IN,
  output logic PWM_A_OUT,
  output logic PWM_B_OUT,
  output logic TripActive,
  output logic ShootThru
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DT_A,
    S_A_ON,
    S_DT_B,
    S_B_ON
  } state_t;

  localparam logic [7:0] DT_LOAD = DEADTIME_CNT[7:0];

  logic   a_meta, a_s, b_meta, b_s, pt_meta, pt_s;
  logic   hold;
  logic   dis, shoot;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;

  assign dis        = !PWMEN || !pt_s || hold;
  assign shoot      = a_s && b_s;
  assign TripActive = hold;

  // NOTE: every clocked block uses non-blocking assignments so all flops update
  // from the same pre-edge values; blocking here would collapse the synchronisers.
  always_ff @(posedge CLK_50M) begin
    if (!Rst_n) begin
      a_meta  <= 1'b0;
      a_s     <= 1'b0;
      b_meta  <= 1'b0;
      b_s     <= 1'b0;
      pt_meta <= 1'b0;
      pt_s    <= 1'b0;
    end else begin
      a_meta  <= PWM_A_IN;
      a_s     <= a_meta;
      b_meta  <= PWM_B_IN;
      b_s     <= b_meta;
      pt_meta <= ProTect;
      pt_s    <= pt_meta;
    end
  end

  // The hold only releases once both commands are back low, so no partial pulse follows a trip.
  always_ff @(posedge CLK_50M) begin
    if (!Rst_n) begin
      hold      <= 1'b1;
      ShootThru <= 1'b0;
    end else begin
      if (!PWMEN || !pt_s || shoot)
        hold <= 1'b1;
      else if (!a_s && !b_s)
        hold <= 1'b0;

      if (shoot)
        ShootThru <= 1'b1;
      else if (ResetD)
        ShootThru <= 1'b0;
    end
  end

  // NOTE: all always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_OFF: begin
        if (!dis) begin
          if (a_s && !b_s) begin
            state_nx = S_DT_A;
            cnt_nx   = DT_LOAD;
          end else if (b_s && !a_s) begin
            state_nx = S_DT_B;
            cnt_nx   = DT_LOAD;
          end
        end
      end
      S_DT_A: begin
        if (dis || !a_s || b_s) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end else if (cnt == 8'd1) begin
          state_nx = S_A_ON;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_A_ON: begin
        if (dis || !a_s || b_s) state_nx = S_OFF;
      end
      S_DT_B: begin
        if (dis || !b_s || a_s) begin
          state_nx = S_OFF;
          cnt_nx   = '0;
        end else if (cnt == 8'd1) begin
          state_nx = S_B_ON;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_B_ON: begin
        if (dis || !b_s || a_s) state_nx = S_OFF;
      end
      default: begin
        state_nx = S_OFF;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each gate is a clean flop output.
  always_ff @(posedge CLK_50M) begin
    if (!Rst_n) begin
      state     <= S_OFF;
      cnt       <= '0;
      PWM_A_OUT <= 1'b0;
      PWM_B_OUT <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      PWM_A_OUT <= (state_nx == S_A_ON);
      PWM_B_OUT <= (state_nx == S_B_ON);
    end
  end

  dt_legal: assert property (@(posedge CLK_50M) (DEADTIME_CNT >= 1) && (DEADTIME_CNT <= 255));

endmodule
